multi_fun_barrel_shifter: RTL and testbench
===========================================

// Module: multi_fun_barrel_shifter
// PURPOSE
// - Registered multi-function barrel shifter: rotates an N-bit operand left or right by 0..N-1.
// - Direction is selected per sample by one bit.
// - Sits in the datapath as a single-stage pipelined shift unit between operand select and result mux.
// - Left and right rotates are both built from one left-rotate core.
// - Right rotate = bit-reverse input, left-rotate, bit-reverse output.
// PARAMETERS
// - WIDTH  8  operand/result width; power of two, >= 2
// - AMT_W  $clog2(WIDTH)  shift-amount width (3 for default)
// PORTS
// - clk         in   1        single clock, rising edge
// - rst_n       in   1        synchronous reset, active-low
// - in_valid    in   1        num/amt/lr sampled this cycle
// - num         in   WIDTH    operand
// - amt         in   AMT_W    shift/rotate amount, unsigned
// - lr          in   1        0 = left, 1 = right
// - out_valid   out  1        shiftedNum holds a new result
// - shiftedNum  out  WIDTH    result
// - Interface: one clock (clk); reset is synchronous and active-low (rst_n).
// BEHAVIOUR
// - Reset: while rst_n==0 at a rising clk, shiftedNum <= 0 and out_valid <= 0.
//   - Reset overrides in_valid in the same cycle.
//   - A result in flight is discarded.
// - Latency 1:
//   - in_valid==1 at edge k -> out_valid==1 and shiftedNum valid after edge k.
//   - No backpressure; a new sample may be accepted every cycle.
// - in_valid==0: out_valid <= 0 and shiftedNum holds its last value.
// - Rotate left (lr=0): shiftedNum = {num[WIDTH-1-amt:0], num[WIDTH-1:WIDTH-amt]}.
// - Rotate right (lr=1): shiftedNum = {num[amt-1:0], num[WIDTH-1:amt]}.
// - amt==0: result = num for either direction.
// - amt==WIDTH-1: left rotate equals right rotate by 1, and vice versa.
// - No overflow or carry outputs; amt is always in range by width.
// - Core: log2(WIDTH) mux stages, stage i rotates by 2^i when amt[i]==1; combinational before the output register.
// CONFIGURATION
// - MFBS_LOGICAL_SHIFT_EN defined:
//   - Adds input port `mode` (1 bit), sampled with in_valid.
//   - mode=0: rotate exactly as above.
//   - mode=1: logical shift; vacated bits are filled with 0 (left: num << amt; right: num >> amt).
// - MFBS_LOGICAL_SHIFT_EN undefined: `mode` port absent; rotate only.
// TESTING
// - Reset: rst_n=0 for 2 cycles with in_valid=1 -> shiftedNum=0x00, out_valid=0.
// - Left rotates, one per cycle:
//   - 00000001 amt=3 -> 00001000.
//   - 00000111 amt=7 -> 10000011.
//   - 11100010 amt=6 -> 10111000.
//   - 00000001 amt=0 -> 00000001.
// - Right rotates:
//   - 01011001 amt=1 -> 10101100.
//   - 00000111 amt=3 -> 11100000.
//   - 01000100 amt=7 -> 10001000.
//   - 00001100 amt=4 -> 11000000.
// - Pipeline: back-to-back in_valid for 12 vectors -> each result 1 cycle later.
//   - Then in_valid=0 -> out_valid=0 and shiftedNum held.
// - Mid-stream reset: rst_n=0 on the cycle after a valid input -> out_valid=0, shiftedNum=0x00 next cycle.
// - With MFBS_LOGICAL_SHIFT_EN, mode=1:
//   - 00000111 right amt=3 -> 00000000.
//   - 11100010 left amt=6 -> 10000000.
//   - 11110000 right amt=1 -> 01111000.

Source files
------------

// File: rtl/multi_fun_barrel_shifter.sv
// Registered rotate unit: left/right rotate by 0..WIDTH-1, one-cycle latency.
// Optional MFBS_LOGICAL_SHIFT_EN adds a `mode` input selecting zero-fill logical shifts.
module multi_fun_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] num,
  input  logic [AMT_W-1:0] amt,
  input  logic             lr,
`ifdef MFBS_LOGICAL_SHIFT_EN
  input  logic             mode,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] shiftedNum
);

  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_core;
  logic [WIDTH-1:0] w_res;
  logic             w_logical;
  logic [WIDTH-1:0] r_shifted;
  logic             r_valid;

`ifdef MFBS_LOGICAL_SHIFT_EN
  assign w_logical = mode;
`else
  assign w_logical = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Right operations reuse the left core by reversing bits before and after;
  // a zero-filled left shift on the reversed word is a logical right shift.
  always_comb begin
    w_src  = lr ? bit_rev(num) : num;
    w_core = w_src;
    for (int unsigned i = 0; i < AMT_W; i++) begin
      if (amt[i]) begin
        if (w_logical) begin
          w_core = w_core << (1 << i);
        end else begin
          w_core = (w_core << (1 << i)) | (w_core >> (WIDTH - (1 << i)));
        end
      end
    end
    w_res = lr ? bit_rev(w_core) : w_core;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_shifted <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_shifted <= w_res;
      end
    end
  end

  assign out_valid  = r_valid;
  assign shiftedNum = r_shifted;

endmodule

// File: tb/tb_multi_fun_barrel_shifter.sv
// Scoreboard bench for multi_fun_barrel_shifter: stimulus pushes expected results,
// a monitor pops and compares whenever out_valid is high.
module tb_multi_fun_barrel_shifter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] num;
  logic [2:0] amt;
  logic       lr;
  logic       mode;
  logic       out_valid;
  logic [7:0] shiftedNum;

  int n_tests;
  int n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp;

  multi_fun_barrel_shifter #(.WIDTH(8), .AMT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .num        (num),
    .amt        (amt),
    .lr         (lr),
`ifdef MFBS_LOGICAL_SHIFT_EN
    .mode       (mode),
`endif
    .out_valid  (out_valid),
    .shiftedNum (shiftedNum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, expv);
    end
  endtask

  // Monitor: sample 1 time unit after the active edge.
  always begin
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got result %b, expected none", shiftedNum);
      end else begin
        e = exp_q.pop_front();
        chk("result", shiftedNum, e);
      end
    end
  end

  // Drive one valid sample at the falling edge and record its expected result.
  task automatic issue(input logic [7:0] n, input logic [2:0] a, input logic dir,
                       input logic md, input logic [7:0] e);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    num      = n;
    amt      = a;
    lr       = dir;
    mode     = md;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    num      = 8'hA5;
    amt      = 3'd5;
  endtask

  typedef struct {
    logic [7:0] n;
    logic [2:0] a;
    logic       dir;
    logic [7:0] e;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8'b00000001, 3'd3, 1'b0, 8'b00001000};
    vecs[1]  = '{8'b00000111, 3'd7, 1'b0, 8'b10000011};
    vecs[2]  = '{8'b11100010, 3'd6, 1'b0, 8'b10111000};
    vecs[3]  = '{8'b00000001, 3'd0, 1'b0, 8'b00000001};
    vecs[4]  = '{8'b01011001, 3'd1, 1'b1, 8'b10101100};
    vecs[5]  = '{8'b00000111, 3'd3, 1'b1, 8'b11100000};
    vecs[6]  = '{8'b01000100, 3'd7, 1'b1, 8'b10001000};
    vecs[7]  = '{8'b00001100, 3'd4, 1'b1, 8'b11000000};
    vecs[8]  = '{8'b10000000, 3'd1, 1'b0, 8'b00000001};
    vecs[9]  = '{8'b10110011, 3'd0, 1'b1, 8'b10110011};
    vecs[10] = '{8'b11001010, 3'd4, 1'b0, 8'b10101100};
    vecs[11] = '{8'b00000001, 3'd1, 1'b1, 8'b10000000};

    n_tests  = 0;
    n_fail   = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    num      = 8'hFF;
    amt      = 3'd3;
    lr       = 1'b0;
    mode     = 1'b0;

    // Reset with in_valid held high for two edges.
    repeat (2) @(negedge clk);
    chk("reset_out_valid", {7'b0, out_valid}, 8'd0);
    chk("reset_shiftedNum", shiftedNum, 8'h00);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Left rotates, then right rotates, one per cycle.
    for (int i = 0; i < 4; i++) issue(vecs[i].n, vecs[i].a, vecs[i].dir, 1'b0, vecs[i].e);
    idle();
    for (int i = 4; i < 8; i++) issue(vecs[i].n, vecs[i].a, vecs[i].dir, 1'b0, vecs[i].e);
    idle();
    @(negedge clk);

    // Back-to-back burst of 12; the last result must arrive the edge after the last input.
    for (int i = 0; i < 12; i++) issue(vecs[i].n, vecs[i].a, vecs[i].dir, 1'b0, vecs[i].e);
    idle();
    chk("burst_drained", 8'(exp_q.size()), 8'd0);
    chk("burst_last_valid", {7'b0, out_valid}, 8'd1);
    @(negedge clk);
    chk("idle_out_valid", {7'b0, out_valid}, 8'd0);
    chk("idle_hold", shiftedNum, last_exp);
    @(negedge clk);
    chk("idle_hold2", shiftedNum, last_exp);

`ifdef MFBS_LOGICAL_SHIFT_EN
    issue(8'b00000111, 3'd3, 1'b1, 1'b1, 8'b00000000);
    issue(8'b11100010, 3'd6, 1'b0, 1'b1, 8'b10000000);
    issue(8'b11110000, 3'd1, 1'b1, 1'b1, 8'b01111000);
    issue(8'b11100010, 3'd6, 1'b0, 1'b0, 8'b10111000);
    idle();
    @(negedge clk);
`endif

    // Mid-stream reset: valid sample, then reset (with in_valid high) the next cycle.
    issue(8'b00110110, 3'd2, 1'b0, 1'b0, 8'b11011000);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    num      = 8'hFF;
    amt      = 3'd1;
    @(negedge clk);
    chk("midreset_out_valid", {7'b0, out_valid}, 8'd0);
    chk("midreset_shiftedNum", shiftedNum, 8'h00);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {7'b0, out_valid}, 8'd0);
    chk("final_queue_empty", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
